mul_seq_ctrl: RTL and testbench

Sequencing controller for the 8-bit shift-add multiplier datapath. Accepts operand pairs on a valid/ready input port and drives the datapath's operand, load and enable lines for exactly one load cycle plus STEPS run cycles. Captures the datapath result into a one-entry output buffer and presents it on a valid/ready output port. Sits between the operand source (upstream) and the multiplier datapath (downstream); stalls without corrupting data when the result consumer back-pressures.

---
 rtl/mul_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_seq_ctrl : load/run/capture sequencer for a shift-add multiplier     |
// |                with a one-entry valid/ready result buffer.               |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mul_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int STEPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_load,
  output logic             mul_en,
  input  logic [WIDTH-1:0] mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_CAPT = 2'd3;

  localparam int            CW     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(STEPS - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_z_q, out_z_d;

  logic             buf_free;
  logic             capture;

  // Draining and refilling the buffer in one cycle is allowed.
  assign buf_free = !out_valid_q || out_ready;
  assign capture  = (state_q == S_CAPT) && buf_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (cnt_q == C_LAST) state_d = S_CAPT;
      S_CAPT:  if (buf_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mul_load = 1'b0;
    mul_en   = 1'b0;
    busy     = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_LOAD: begin
        mul_load = 1'b1;
        mul_en   = 1'b1;
      end
      S_RUN:   mul_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;

    if (state_q == S_LOAD) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) && (cnt_q != C_LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Operands are only sampled on an accepted handshake.
    if ((state_q == S_IDLE) && in_valid) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
    end

    if (capture) begin
      out_valid_d = 1'b1;
      out_z_d     = mul_z;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_seq_ctrl : directed and randomized bench for mul_seq_ctrl.        |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_mul_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int STEPS = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             mul_load, mul_en;
  logic [WIDTH-1:0] mul_z;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_z;
  logic             busy;

  mul_seq_ctrl #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_en(mul_en),
    .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: product appears only after the STEPS-th enable following load.
  int          st_cnt = 0;
  logic [7:0]  st_z   = 8'd0;
  logic [15:0] st_p;
  assign st_p  = mul_a * mul_b;
  assign mul_z = st_z;
  always @(posedge clk) begin
    if (mul_load) begin
      st_cnt <= 1;
      st_z   <= 8'd0;
    end else if (mul_en) begin
      st_cnt <= st_cnt + 1;
      if (st_cnt + 1 == STEPS + 1) st_z <= st_p[7:0];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an operation is just "cycles since handshake" (k).
  bit   m_init = 0;
  bit   m_act  = 0;
  int   m_k    = 0;
  bit   m_ov   = 0;
  int   m_oz   = 0;
  int   m_ma   = 0;
  int   m_mb   = 0;
  int   m_prod = 0;
  bit   m_cap;

  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready",  in_ready,  !m_act);
      check("busy",      busy,      m_act);
      check("mul_load",  mul_load,  m_act && m_k == 1);
      check("mul_en",    mul_en,    m_act && m_k <= STEPS + 1);
      check("out_valid", out_valid, m_ov);
      check("out_z",     out_z,     m_oz);
      check("mul_a",     mul_a,     m_ma);
      check("mul_b",     mul_b,     m_mb);
    end
    if (out_valid && out_ready && !reset) got.push_back(out_z);
    if (reset) begin
      m_init = 1; m_act = 0; m_k = 0; m_ov = 0; m_oz = 0; m_ma = 0; m_mb = 0;
    end else if (m_init) begin
      m_cap = m_act && m_k >= STEPS + 2 && (!m_ov || out_ready);
      if (m_cap) begin
        m_ov = 1; m_oz = m_prod; m_act = 0;
      end else begin
        if (m_ov && out_ready) m_ov = 0;
        if (m_act) m_k++;
        else if (in_valid) begin
          m_act = 1; m_k = 1; m_ma = in_a; m_mb = in_b;
          m_prod = (m_ma * m_mb) % 256;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int a, input int b, output int hs);
    bit rdy;
    bit done;
    done = 0;
    hs = -1;
    in_valid = 1'b1;
    in_a = 8'(a);
    in_b = 8'(b);
    for (int i = 0; i < 60; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        hs = cyc;
        done = 1;
        break;
      end
    end
    if (!done) check("handshake_timeout", 0, 1);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 60 && got.size() < n; i++) tick();
    check("result_count", got.size(), n);
  endtask

  int h0, h1, h2;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_busy", busy, 0);

    // Single product 13*11
    tick();
    got.delete();
    op(13, 11, h0);
    in_valid = 1'b0;
    check("t1_load", mul_load, 1);
    check("t1_en", mul_en, 1);
    for (int i = 2; i <= 9; i++) begin
      tick();
      check("run_load", mul_load, 0);
      check("run_en", mul_en, 1);
    end
    tick();
    check("capt_en", mul_en, 0);
    check("capt_ov", out_valid, 0);
    tick();
    check("t11_ov", out_valid, 1);
    check("t11_z", out_z, 143);
    check("t11_in_ready", in_ready, 1);
    tick();
    check("t12_ov", out_valid, 0);

    // Back-to-back
    got.delete();
    op(3, 5, h0);
    op(255, 2, h1);
    op(16, 16, h2);
    in_valid = 1'b0;
    check("b2b_gap1", h1 - h0, 11);
    check("b2b_gap2", h2 - h1, 11);
    wait_results(3);
    if (got.size() == 3) begin
      check("b2b_r0", got[0], 15);
      check("b2b_r1", got[1], 254);
      check("b2b_r2", got[2], 0);
    end
    tick(); tick();

    // Back-pressure
    got.delete();
    out_ready = 1'b0;
    op(7, 9, h0);
    op(2, 4, h1);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("bp_ov", out_valid, 1);
    check("bp_z", out_z, 63);
    check("bp_en", mul_en, 0);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    out_ready = 1'b1;
    tick();
    check("bp_swap_ov", out_valid, 1);
    check("bp_swap_z", out_z, 8);
    check("bp_idle", busy, 0);
    tick();
    check("bp_drain_ov", out_valid, 0);
    check("bp_count", got.size(), 2);
    if (got.size() == 2) begin
      check("bp_r0", got[0], 63);
      check("bp_r1", got[1], 8);
    end

    // Reset mid-run
    op(9, 9, h0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_en", mul_en, 0);
    check("mr_load", mul_load, 0);
    check("mr_busy", busy, 0);
    check("mr_in_ready", in_ready, 1);
    got.delete();
    for (int i = 0; i < 15; i++) begin
      check("mr_no_ov", out_valid, 0);
      tick();
    end
    op(2, 3, h0);
    in_valid = 1'b0;
    wait_results(1);
    if (got.size() == 1) check("mr_r", got[0], 6);

    // Ignored input while running
    tick();
    got.delete();
    op(5, 6, h0);
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      tick();
      check("ign_a", mul_a, 5);
      check("ign_b", mul_b, 6);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("ign_count", got.size(), 1);
    if (got.size() == 1) check("ign_r", got[0], 30);
    check("ign_idle", busy, 0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 249) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
